// File: rtl/adder_cap_pkg.sv
// Shared types and defaults for the adder result capture block.
package adder_cap_pkg;

    localparam int unsigned WIDTH_DEF   = 16;
    localparam int unsigned DEPTH_DEF   = 4;
    localparam int unsigned TIMEOUT_DEF = 64;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // One queued result: raw adder outputs plus flags derived at capture.
    typedef struct packed {
        logic [WIDTH_DEF-1:0] sum;
        logic                 cout;
        logic                 zero;
        logic                 neg;
        logic                 ovf;
    } result_t;

endpackage

// File: rtl/adder_result_capture_if.sv
// Adder-side inputs and ALU-side result/status signals of the capture block.
interface adder_result_capture_if
    import adder_cap_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             op_start;
    logic             op_a_msb;
    logic             op_b_msb;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             calc_done;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_cout;
    logic             res_zero;
    logic             res_neg;
    logic             res_ovf;
    logic [CW-1:0]    fifo_count;
    logic             busy;
    logic             timeout_err;
    logic             drop_err;
    logic             err_clr;

    modport master (
        input  op_start, op_a_msb, op_b_msb, sum, cout, calc_done, res_ready, err_clr,
        output res_valid, res_data, res_cout, res_zero, res_neg, res_ovf,
               fifo_count, busy, timeout_err, drop_err
    );

    modport slave (
        output op_start, op_a_msb, op_b_msb, sum, cout, calc_done, res_ready, err_clr,
        input  res_valid, res_data, res_cout, res_zero, res_neg, res_ovf,
               fifo_count, busy, timeout_err, drop_err
    );

endinterface

// File: rtl/adder_result_capture_fifo.sv
// First-word-fall-through result FIFO with a registered head and a drop indication.
module result_fifo
    import adder_cap_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   ready,
    input  result_t                din,
    output result_t                head,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop_c
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    result_t       mem_q [DEPTH];
    result_t       mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_d;
    result_t       head_d;
    logic          full_c, do_pop, do_push;

    // Next storage/pointer state; the head register is loaded from the post-update view.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        full_c  = (count == CW'(DEPTH));
        do_pop  = valid & ready;
        do_push = push & (~full_c | do_pop);
        drop_c  = push & full_c & ~do_pop;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        cnt_d  = count + CW'(do_push) - CW'(do_pop);
        head_d = (cnt_d != '0) ? mem_d[rd_d] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            count <= '0;
            valid <= 1'b0;
            head  <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            count <= cnt_d;
            valid <= (cnt_d != '0);
            head  <= head_d;
        end
    end

endmodule

// File: rtl/adder_result_capture.sv
// Tracks each adder operation to its calc_done rising edge and queues sum/carry/flags.
module adder_result_capture
    import adder_cap_pkg::*;
#(
    parameter int unsigned WIDTH          = WIDTH_DEF,
    parameter int unsigned DEPTH          = DEPTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    adder_result_capture_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES) + 1;

    state_t        state_q, state_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          a_q, a_d, b_q, b_d;
    logic          done_q, done_rise_c;
    logic          push_c, tmo_c, drop_c;
    logic          timeout_q, timeout_d, drop_q, drop_d, busy_q, busy_d;
    result_t       entry_c, head;
    logic          fifo_valid;
    logic [CW-1:0] fifo_count;

    assign done_rise_c = bus.calc_done & ~done_q;

    // Flags are taken from the live sum in the capture cycle.
    always_comb begin
        entry_c      = '0;
        entry_c.sum  = bus.sum;
        entry_c.cout = bus.cout;
        entry_c.zero = (bus.sum == '0);
        entry_c.neg  = bus.sum[WIDTH-1];
        entry_c.ovf  = (a_q == b_q) && (bus.sum[WIDTH-1] != a_q);
    end

    // Next-state: a rising calc_done beats the watchdog limit in the same cycle.
    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        a_d     = a_q;
        b_d     = b_q;
        push_c  = 1'b0;
        tmo_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.op_start) begin
                    a_d     = bus.op_a_msb;
                    b_d     = bus.op_b_msb;
                    wdog_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                wdog_d = wdog_q + WW'(1);
                if (done_rise_c) begin
                    push_c  = 1'b1;
                    state_d = IDLE;
                end else if (wdog_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_c   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        timeout_d = tmo_c | (timeout_q & ~bus.err_clr);
        drop_d    = drop_c | (drop_q & ~bus.err_clr);
        busy_d    = (state_d == WAIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wdog_q    <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            drop_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            a_q       <= a_d;
            b_q       <= b_d;
            done_q    <= bus.calc_done;
            timeout_q <= timeout_d;
            drop_q    <= drop_d;
            busy_q    <= busy_d;
        end
    end

    result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push_c),
        .ready  (bus.res_ready),
        .din    (entry_c),
        .head   (head),
        .valid  (fifo_valid),
        .count  (fifo_count),
        .drop_c (drop_c)
    );

    assign bus.res_valid   = fifo_valid;
    assign bus.res_data    = head.sum;
    assign bus.res_cout    = head.cout;
    assign bus.res_zero    = head.zero;
    assign bus.res_neg     = head.neg;
    assign bus.res_ovf     = head.ovf;
    assign bus.fifo_count  = fifo_count;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_q;
    assign bus.drop_err    = drop_q;

endmodule
